countdown_ctrl: RTL

//  Clocked sequencer for the N-bit down-counter datapath feeding the BCD/7-seg display chain.
//  - Debounces the raw btn_sub and btn_start push-buttons.
//  - Loads the switch value and decrements it manually (btn_sub) or automatically (tick timer).
//  - Flags terminal count.
//  - Its count output drives the binary-to-BCD converter directly.

---
 rtl/countdown_ctrl_if.sv | 22 ++
 rtl/countdown_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/countdown_ctrl_if.sv
// rtl/countdown_ctrl_if.sv - button, switch and display-side signals of the countdown sequencer
interface countdown_ctrl_if #(
    parameter int N = 6
);
    logic         btn_sub;
    logic         btn_start;
    logic [N-1:0] data_in;
    logic [N-1:0] count;
    logic [1:0]   state;
    logic         zero_flag;
    logic         reload_pulse;

    modport master (
        output btn_sub, btn_start, data_in,
        input  count, state, zero_flag, reload_pulse
    );

    modport slave (
        input  btn_sub, btn_start, data_in,
        output count, state, zero_flag, reload_pulse
    );
endinterface

// File: rtl/countdown_ctrl.sv
// rtl/countdown_ctrl.sv - debounced down-counter sequencer; optional auto-reload via CTRL_AUTORELOAD_EN
module countdown_ctrl #(
    parameter int N           = 6,
    parameter int DEB_CYCLES  = 500000,
    parameter int TICK_CYCLES = 50000000
) (
    input  logic             clk,
    input  logic             btn_rst,
    countdown_ctrl_if.slave  bus
);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int TW = $clog2(TICK_CYCLES + 1);
    localparam logic [N-1:0]  CNT_ONE  = 1;
    localparam logic [DW-1:0] DEB_ONE  = 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0] TICK_ONE  = 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MAN  = 2'b01,
        RUN  = 2'b10,
        DONE = 2'b11
    } state_t;

    // Button index 0 is btn_sub, index 1 is btn_start; buttons are active-low.
    logic [1:0]         sync1_q, sync1_d;
    logic [1:0]         sync2_q, sync2_d;
    logic [1:0]         stable_q, stable_d;
    logic [1:0]         press_q, press_d;
    logic [1:0][DW-1:0] deb_cnt_q, deb_cnt_d;

    state_t             state_q, state_d;
    logic [N-1:0]       count_q, count_d;
    logic [TW-1:0]      tick_q, tick_d;

    logic sub_p;
    logic start_p;

    // Button front end: a press pulse is raised only when a low level has been stable long enough.
    always_comb begin
        sync1_d   = {bus.btn_start, bus.btn_sub};
        sync2_d   = sync1_q;
        stable_d  = stable_q;
        press_d   = '0;
        deb_cnt_d = deb_cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != stable_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    stable_d[i]  = sync2_q[i];
                    deb_cnt_d[i] = '0;
                    press_d[i]   = ~sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DEB_ONE;
                end
            end else begin
                deb_cnt_d[i] = '0;
            end
        end
    end

    assign sub_p   = press_q[0];
    assign start_p = press_q[1];

`ifdef CTRL_AUTORELOAD_EN
    logic reload_q, reload_d;
`endif

    // Sequencer: next state, counter and tick timer; start_p always takes priority over sub_p.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tick_d  = tick_q;
`ifdef CTRL_AUTORELOAD_EN
        reload_d = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                count_d = bus.data_in;
                if (start_p) begin
                    state_d = RUN;
                    tick_d  = '0;
                end else if (sub_p) begin
                    if (bus.data_in == '0) begin
                        state_d = DONE;
                        count_d = '0;
                    end else begin
                        state_d = MAN;
                        count_d = bus.data_in - CNT_ONE;
                    end
                end
            end
            MAN: begin
                if (start_p) begin
                    state_d = RUN;
                    tick_d  = '0;
                end else if (sub_p) begin
                    // A pause at zero leaves MAN holding 0; treat the next press as terminal.
                    if (count_q <= CNT_ONE) begin
                        state_d = DONE;
                        count_d = '0;
                    end else begin
                        count_d = count_q - CNT_ONE;
                    end
                end
            end
            RUN: begin
                if (start_p) begin
                    state_d = MAN;
                end else if (count_q == '0) begin
                    state_d = DONE;
                end else if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    if (count_q == CNT_ONE) begin
`ifdef CTRL_AUTORELOAD_EN
                        if (bus.data_in != '0) begin
                            count_d  = bus.data_in;
                            reload_d = 1'b1;
                        end else begin
                            state_d = DONE;
                            count_d = '0;
                        end
`else
                        state_d = DONE;
                        count_d = '0;
`endif
                    end else begin
                        count_d = count_q - CNT_ONE;
                    end
                end else begin
                    tick_d = tick_q + TICK_ONE;
                end
            end
            DONE: begin
                count_d = '0;
                if (start_p) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; synchronizers come out of reset at the released (high) level.
    always_ff @(posedge clk or negedge btn_rst) begin
        if (!btn_rst) begin
            sync1_q   <= 2'b11;
            sync2_q   <= 2'b11;
            stable_q  <= 2'b11;
            press_q   <= '0;
            deb_cnt_q <= '0;
            state_q   <= IDLE;
            count_q   <= '0;
            tick_q    <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            stable_q  <= stable_d;
            press_q   <= press_d;
            deb_cnt_q <= deb_cnt_d;
            state_q   <= state_d;
            count_q   <= count_d;
            tick_q    <= tick_d;
        end
    end

`ifdef CTRL_AUTORELOAD_EN
    // Reload strobe register, high for the single cycle after an auto-reload.
    always_ff @(posedge clk or negedge btn_rst) begin
        if (!btn_rst) begin
            reload_q <= 1'b0;
        end else begin
            reload_q <= reload_d;
        end
    end
    assign bus.reload_pulse = reload_q;
`else
    assign bus.reload_pulse = 1'b0;
`endif

    assign bus.count     = count_q;
    assign bus.state     = state_q;
    assign bus.zero_flag = (state_q == DONE);
endmodule
